// File: rtl/eth_mac_pkg.sv
// Shared types and constants for the MAC
// receive/transmit frame FIFOs.
package eth_mac_pkg;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_STORE   = 2'd1,
    W_DISCARD = 2'd2
  } wr_state_e;

  localparam int unsigned RAM_DW       = 9;
  localparam int unsigned RAM_LAST_BIT = 8;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM, one write port and
// one read port with a registered read.
module eth_sdp_ram #(
  parameter int unsigned DW = 9,
  parameter int unsigned AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Write on we, read data held until next re.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tri_mode_ethernet_mac_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO: commits good
// frames, drops bad/overflowing ones whole.
module tri_mode_ethernet_mac_rx_frame_fifo
  import eth_mac_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 11,
  parameter int unsigned C_CNT_WIDTH  = 8
) (
  input  logic                   rx_mac_aclk,
  input  logic                   rx_mac_reset,
  input  logic [7:0]             rx_axis_mac_tdata,
  input  logic                   rx_axis_mac_tvalid,
  input  logic                   rx_axis_mac_tlast,
  input  logic                   rx_axis_mac_tuser,
  output logic [7:0]             rx_axis_fifo_tdata,
  output logic                   rx_axis_fifo_tvalid,
  input  logic                   rx_axis_fifo_tready,
  output logic                   rx_axis_fifo_tlast,
  output logic [C_CNT_WIDTH-1:0] rx_fifo_frame_cnt,
  output logic                   rx_fifo_good_frame,
  output logic                   rx_fifo_bad_frame,
  output logic                   rx_fifo_overflow
);

  localparam int unsigned PW = C_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [PW-1:0] DEPTH =
    {1'b1, {C_ADDR_WIDTH{1'b0}}};
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE =
    C_CNT_WIDTH'(1);

  wr_state_e               state_q;
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           wr_commit_q;
  logic [PW-1:0]           rd_ptr_q;
  logic                    good_q;
  logic                    bad_q;
  logic                    ovf_q;
  logic                    pend_q;
  logic                    vld_q;
  logic [RAM_DW-1:0]       word_q;
  logic [C_CNT_WIDTH-1:0]  cnt_q;
  logic [C_CNT_WIDTH-1:0]  cnt_d;

  logic              accept;
  logic              full;
  logic              ovf;
  logic              wr_en;
  logic              commit;
  logic              bad;
  logic              hs;
  logic              load;
  logic              issue;
  logic              dec;
  logic [RAM_DW-1:0] ram_rdata;

  assign accept = rx_axis_mac_tvalid &&
                  (state_q != W_DISCARD);
  assign full   = (wr_ptr_q - rd_ptr_q) == DEPTH;
  assign ovf    = accept && full;
  assign wr_en  = accept && !full;
  assign commit = wr_en && rx_axis_mac_tlast &&
                  !rx_axis_mac_tuser;
  assign bad    = wr_en && rx_axis_mac_tlast &&
                  rx_axis_mac_tuser;

  // Output register is refilled from the RAM
  // stage; the RAM stage is refilled whenever
  // it is empty or emptying this cycle.
  assign hs    = vld_q && rx_axis_fifo_tready;
  assign load  = pend_q && (!vld_q || hs);
  assign issue = (rd_ptr_q != wr_commit_q) &&
                 (!pend_q || load);
  assign dec   = hs && word_q[RAM_LAST_BIT] &&
                 (cnt_q != '0);

  eth_sdp_ram #(
    .DW (RAM_DW),
    .AW (C_ADDR_WIDTH)
  ) u_ram (
    .clk_i   (rx_mac_aclk),
    .we_i    (wr_en && !rx_mac_reset),
    .waddr_i (wr_ptr_q[C_ADDR_WIDTH-1:0]),
    .wdata_i ({rx_axis_mac_tlast,
               rx_axis_mac_tdata}),
    .re_i    (issue),
    .raddr_i (rd_ptr_q[C_ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  // Saturating stored-frame count.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({commit, dec})
      2'b10: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      end
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Write FSM: speculative write, commit or rewind.
  always_ff @(posedge rx_mac_aclk) begin
    if (rx_mac_reset) begin
      state_q     <= W_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      good_q <= commit;
      bad_q  <= bad;
      ovf_q  <= ovf;
      unique case (state_q)
        W_IDLE, W_STORE: begin
          if (ovf) begin
            wr_ptr_q <= wr_commit_q;
            state_q  <= rx_axis_mac_tlast ?
                        W_IDLE : W_DISCARD;
          end else if (bad) begin
            wr_ptr_q <= wr_commit_q;
            state_q  <= W_IDLE;
          end else if (commit) begin
            wr_ptr_q    <= wr_ptr_q + PONE;
            wr_commit_q <= wr_ptr_q + PONE;
            state_q     <= W_IDLE;
          end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PONE;
            state_q  <= W_STORE;
          end
        end
        W_DISCARD: begin
          if (rx_axis_mac_tvalid && rx_axis_mac_tlast)
            state_q <= W_IDLE;
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  // Read side: RAM stage plus output register.
  always_ff @(posedge rx_mac_aclk) begin
    if (rx_mac_reset) begin
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      vld_q    <= 1'b0;
      word_q   <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (issue) rd_ptr_q <= rd_ptr_q + PONE;
      if (issue)     pend_q <= 1'b1;
      else if (load) pend_q <= 1'b0;
      if (load) begin
        vld_q  <= 1'b1;
        word_q <= ram_rdata;
      end else if (hs) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign rx_axis_fifo_tdata  = word_q[7:0];
  assign rx_axis_fifo_tlast  = word_q[RAM_LAST_BIT];
  assign rx_axis_fifo_tvalid = vld_q;
  assign rx_fifo_frame_cnt   = cnt_q;
  assign rx_fifo_good_frame  = good_q;
  assign rx_fifo_bad_frame   = bad_q;
  assign rx_fifo_overflow    = ovf_q;

endmodule

// File: tb/tb_tri_mode_ethernet_mac_rx_frame_fifo.sv
// Directed bench for the RX frame FIFO.
// Expected streams are built by the sender.
module tb_tri_mode_ethernet_mac_rx_frame_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mdata;
  logic       mvalid;
  logic       mlast;
  logic       muser;
  logic       tready_man;
  logic       rnd_en;
  logic       rnd_bit;
  logic       tready;
  logic [7:0] fdata;
  logic       fvalid;
  logic       flast;
  logic [7:0] fcnt;
  logic       good;
  logic       bad;
  logic       ovf;

  int passes;
  int total;
  int fails;
  int n_good;
  int n_bad;
  int n_ovf;
  int ovf_at;
  int sent;
  int gbase;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  assign tready = rnd_en ? rnd_bit : tready_man;

  tri_mode_ethernet_mac_rx_frame_fifo dut (
    .rx_mac_aclk         (clk),
    .rx_mac_reset        (rst),
    .rx_axis_mac_tdata   (mdata),
    .rx_axis_mac_tvalid  (mvalid),
    .rx_axis_mac_tlast   (mlast),
    .rx_axis_mac_tuser   (muser),
    .rx_axis_fifo_tdata  (fdata),
    .rx_axis_fifo_tvalid (fvalid),
    .rx_axis_fifo_tready (tready),
    .rx_axis_fifo_tlast  (flast),
    .rx_fifo_frame_cnt   (fcnt),
    .rx_fifo_good_frame  (good),
    .rx_fifo_bad_frame   (bad),
    .rx_fifo_overflow    (ovf)
  );

  // Output collector and pulse counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (fvalid && tready) got.push_back({flast, fdata});
      if (good) n_good <= n_good + 1;
      if (bad)  n_bad  <= n_bad + 1;
      if (ovf) begin
        n_ovf  <= n_ovf + 1;
        ovf_at <= sent;
      end
    end
  end

  // Random ready source.
  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int n,
                            input logic [7:0] base,
                            input logic is_bad,
                            input logic keep);
    for (int i = 0; i < n; i++) begin
      mdata  = base + 8'(i);
      mvalid = 1'b1;
      mlast  = (i == n - 1);
      muser  = is_bad && (i == n - 1);
      if (keep) exp_q.push_back({mlast, mdata});
      @(posedge clk);
      #1;
      sent++;
    end
    mvalid = 1'b0;
    mlast  = 1'b0;
    muser  = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int i;
    i = 0;
    while ((got.size() - gbase < exp_q.size()) &&
           (i < maxc)) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_len"}, got.size() - gbase,
          exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (gbase + i < got.size())
        check(tag, 32'(got[gbase + i]),
              32'(exp_q[i]));
    gbase = got.size();
    exp_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    mdata      = '0;
    mvalid     = 1'b0;
    mlast      = 1'b0;
    muser      = 1'b0;
    tready_man = 1'b0;
    rnd_en     = 1'b0;
    sent       = 0;
    gbase      = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", fvalid, 0);
    check("rst_tlast", flast, 0);
    check("rst_tdata", fdata, 0);
    check("rst_cnt", fcnt, 0);
    check("rst_good", good, 0);
    check("rst_bad", bad, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Good 64-byte frame, latency and count.
    tready_man = 1'b1;
    send_frame(64, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_good", good, 1);
    check("t1_cnt1", fcnt, 1);
    check("t1_vld_T", fvalid, 0);
    @(negedge clk);
    check("t1_vld_T1", fvalid, 0);
    @(negedge clk);
    check("t1_vld_T2", fvalid, 1);
    check("t1_first", fdata, 8'h00);
    drain(200);
    cmp_frames("t1_data");
    check("t1_cnt0", fcnt, 0);

    // Bad frame dropped, next good frame intact.
    send_frame(64, 8'h20, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_bad", bad, 1);
    check("t2_noout", fvalid, 0);
    send_frame(60, 8'h80, 1'b0, 1'b1);
    drain(200);
    cmp_frames("t2_data");
    check("t2_nbad", n_bad, 1);
    check("t2_ngood", n_good, 2);

    // Overflow with no reader.
    tready_man = 1'b0;
    sent = 0;
    send_frame(2100, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t3_novf", n_ovf, 1);
    check("t3_ovf_at", ovf_at, 2049);
    check("t3_ngood", n_good, 2);
    check("t3_cnt", fcnt, 0);
    check("t3_noout", fvalid, 0);
    tready_man = 1'b1;
    send_frame(100, 8'h10, 1'b0, 1'b1);
    drain(300);
    cmp_frames("t3_data");
    check("t3_novf2", n_ovf, 1);

    // Three back-to-back frames, random ready.
    tready_man = 1'b0;
    send_frame(10, 8'hA0, 1'b0, 1'b1);
    send_frame(1, 8'h55, 1'b0, 1'b1);
    send_frame(20, 8'hC0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_cnt3", fcnt, 3);
    rnd_en = 1'b1;
    drain(600);
    rnd_en = 1'b0;
    check("t4_onebyte",
          (got.size() > gbase + 10) ?
            32'(got[gbase + 10]) : 32'hFFFF,
          32'h155);
    cmp_frames("t4_data");
    check("t4_cnt0", fcnt, 0);

    // Commit coincides with last-byte handshake.
    tready_man = 1'b0;
    send_frame(4, 8'h30, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("t5_cntA", fcnt, 1);
    check("t5_vldA", fvalid, 1);
    check("t5_dataA", fdata, 8'h30);
    tready_man = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mdata  = 8'h40 + 8'(k);
      mvalid = 1'b1;
      mlast  = (k == 3);
      muser  = 1'b0;
      exp_q.push_back({mlast, mdata});
      if (k > 0) @(negedge clk);
      check("t5_cnt_hold", fcnt, 1);
      @(posedge clk);
      #1;
    end
    mvalid = 1'b0;
    mlast  = 1'b0;
    @(negedge clk);
    check("t5_cnt_same", fcnt, 1);
    check("t5_good", good, 1);
    drain(100);
    cmp_frames("t5_data");
    check("t5_cnt0", fcnt, 0);

    // Reset in the middle of output.
    send_frame(50, 8'h00, 1'b0, 1'b1);
    for (int i = 0;
         i < 200 && got.size() < gbase + 10; i++)
      @(negedge clk);
    check("t6_mid", fvalid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_vld0", fvalid, 0);
    check("t6_cnt0", fcnt, 0);
    exp_q.delete();
    gbase = got.size();
    repeat (5) @(negedge clk);
    check("t6_still0", fvalid, 0);
    send_frame(30, 8'h70, 1'b0, 1'b1);
    drain(100);
    cmp_frames("t6_data");
    check("t6_cnt_end", fcnt, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/tri_mode_ethernet_mac_rx_frame_fifo.md
Name: tri_mode_ethernet_mac_rx_frame_fifo

Overview:
Store-and-forward receive frame FIFO directly downstream of the tri-mode MAC receiver. Buffers each frame from the MAC AXI-Stream, which has no tready, and commits it only when tlast arrives with tuser=0. Frames flagged bad by the MAC (tuser=1 at tlast) or overflowing the buffer are discarded whole. Committed frames are replayed on a back-pressured AXI-Stream to the ARP/IP user logic.

Parameters:
C_ADDR_WIDTH, 11, log2 of buffer depth in bytes (2048 bytes; holds one max-size 1500-byte payload frame plus headroom)
C_CNT_WIDTH, 8, width of the stored-frame counter; saturates at 2^C_CNT_WIDTH-1

Ports:
rx_mac_aclk  in  1  single clock for the whole block
rx_mac_reset  in  1  synchronous, active-high reset
rx_axis_mac_tdata  in  8  frame byte from the MAC
rx_axis_mac_tvalid  in  1  byte valid; no backpressure possible
rx_axis_mac_tlast  in  1  last byte of frame
rx_axis_mac_tuser  in  1  frame bad; sampled only with tvalid&tlast
rx_axis_fifo_tdata  out  8  output byte
rx_axis_fifo_tvalid  out  1  output valid
rx_axis_fifo_tready  in  1  downstream ready
rx_axis_fifo_tlast  out  1  last byte of output frame
rx_fifo_frame_cnt  out  C_CNT_WIDTH  committed frames not yet fully read
rx_fifo_good_frame  out  1  1-cycle pulse: frame committed
rx_fifo_bad_frame  out  1  1-cycle pulse: frame dropped because tuser=1
rx_fifo_overflow  out  1  1-cycle pulse: frame dropped because the buffer was full

Behaviour:
- Reset is synchronous and active-high on rx_mac_aclk. Clear all pointers, counters and states. All outputs are 0 at reset.
- Storage: 2^C_ADDR_WIDTH x 9-bit simple dual-port RAM holding {tlast, tdata}, with 1-cycle registered read.
- Pointers are C_ADDR_WIDTH+1 bits and wrap naturally:
  - wr_ptr: speculative write pointer.
  - wr_commit: committed write pointer.
  - rd_ptr: read pointer.
- Full condition: (wr_ptr - rd_ptr) == 2^C_ADDR_WIDTH.
- Write FSM:
  - W_IDLE: on tvalid, write the byte and advance wr_ptr, then go to W_STORE. If tlast is also set, handle it as in W_STORE, so 1-byte frames are legal.
  - W_STORE: on each tvalid byte, write it and advance wr_ptr. On tvalid&tlast:
    - tuser=0: wr_commit <= wr_ptr+1, pulse good_frame, go to W_IDLE.
    - tuser=1: wr_ptr <= wr_commit, pulse bad_frame, go to W_IDLE.
  - Full while a tvalid byte arrives (not tlast): wr_ptr <= wr_commit, pulse overflow, go to W_DISCARD.
  - Full on the tlast byte: treat as overflow and drop; no commit.
  - W_DISCARD: ignore bytes; on tvalid&tlast go to W_IDLE. No second pulse is issued.
- Read side uses an output register with one-entry prefetch:
  - A read is issued when rd_ptr != wr_commit and the output register is empty or being consumed this cycle (tvalid&tready).
  - Sustained throughput is 1 byte/cycle while tready=1.
  - Latency: the edge capturing a good tlast is edge T; the first byte's tvalid is high after edge T+2 if the FIFO was previously empty.
- tvalid/tdata/tlast stay stable while tvalid&!tready (AXI-Stream rule).
- rx_fifo_frame_cnt:
  - +1 on commit; -1 on an output handshake with tlast.
  - Both in the same cycle: no change.
  - Saturates at the maximum value and never underflows.
- Commit/read concurrency: rd_ptr never passes wr_commit, so uncommitted bytes are never emitted.
- A drop (rewind) never touches data between rd_ptr and wr_commit.
- Reset mid-frame or mid-output: all buffered data is lost, and the outputs drop to 0 on the next edge.

Decomposition:
- Shared package eth_mac_pkg holds:
  - write-FSM state constants W_IDLE/W_STORE/W_DISCARD;
  - RAM word layout constants (bit 8 = tlast).
- One natural sub-module: eth_sdp_ram (parameterised width/depth simple dual-port RAM with registered read), reusable by the TX FIFO.

Test Plan:
- Good 64-byte frame (bytes 0x00..0x3F, tuser=0), tready=1 -> good_frame pulse; output 0x00..0x3F with tlast only on 0x3F; first tvalid 2 cycles after the input tlast; frame_cnt goes 0->1->0.
- 64-byte frame with tuser=1 at tlast, then a good 60-byte frame -> bad_frame pulse; only the 60-byte frame appears; wr_ptr rewound so the output starts at the new frame's first byte.
- tready=0, stream 2100-byte frame -> overflow pulse once at byte 2049; no output; a following good 100-byte frame is emitted intact.
- Three back-to-back good frames (10, 1, 20 bytes) with random tready -> exact byte order and tlast positions preserved; frame_cnt peaks at 3; 1-byte frame has tvalid&tlast together.
- Good frame committed in the same cycle as the last-byte handshake of the previous frame -> frame_cnt unchanged that cycle; no gap or duplicate.
- Assert rx_mac_reset mid-output of a 50-byte frame -> tvalid=0, frame_cnt=0 next cycle; a post-reset good frame is delivered correctly.
